// File: rtl/draw_engine_pkg.sv
// draw_engine_pkg: shared geometry constants and FSM state encoding
package draw_engine_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;
  localparam int ADDR_W   = 15;
  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
endpackage

// File: rtl/draw_counter.sv
// draw_counter: row-major col/row scan over a runtime-sized rectangle
module draw_counter
  import draw_engine_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        w,
  input  logic [6:0]        h,
  output logic [7:0]        col,
  output logic [6:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [7:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              eol;
  assign eol  = col_q == w - 8'd1;
  assign last = eol && row_q == h - 7'd1;
  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;
  // step along the row, wrap at the right edge; the scan is row-major so the
  // linear address is simply the number of steps taken (row*w + col)
  always_comb begin
    col_d  = clr ? '0 : en ? (eol ? '0 : col_q + 8'd1) : col_q;
    row_d  = clr ? '0 : (en && eol) ? row_q + 7'd1 : row_q;
    addr_d = clr ? '0 : en ? addr_q + ADDR_W'(1) : addr_q;
  end
  // position registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/draw_engine.sv
// draw_engine: streams a screen or sprite from ROM to a VGA pixel port
module draw_engine
  import draw_engine_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              spriteMode,
  input  logic [7:0]        xInit,
  input  logic [6:0]        yInit,
  input  logic              black,
  input  logic [2:0]        romData,
  output logic [ADDR_W-1:0] romAddr,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic              mode_q, black_q, pix_q, clip_q, accept, last;
  logic [7:0]        xinit_q, x_q, w, col;
  logic [6:0]        yinit_q, y_q, h, row;
  logic [2:0]        colour_q;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        xs;
  logic [7:0]        ys;
  assign accept = state_q == IDLE && start;
  assign w      = mode_q ? 8'(SPRITE_W) : 8'(SCREEN_W);
  assign h      = mode_q ? 7'(SPRITE_H) : 7'(SCREEN_H);
  assign xs     = 9'(xinit_q) + 9'(col);
  assign ys     = 8'(yinit_q) + 8'(row);
  draw_counter u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .en     (state_q == DRAW),
    .w      (w),
    .h      (h),
    .col    (col),
    .row    (row),
    .addr   (addr),
    .last   (last)
  );
  // next state and state-derived outputs
  always_comb begin
    state_d = accept ? DRAW :
              state_q == DRAW  ? (last ? FLUSH : DRAW) :
              state_q == FLUSH ? DONE :
              state_q == DONE  ? IDLE : state_q;
    romAddr = state_q == DRAW ? addr : '0;
    busy    = state_q == DRAW || state_q == FLUSH;
    done    = state_q == DONE;
  end
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // draw parameters captured only when a request is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= 1'b0;
      black_q <= 1'b0;
      xinit_q <= '0;
      yinit_q <= '0;
    end else if (accept) begin
      mode_q  <= spriteMode;
      black_q <= black;
      xinit_q <= xInit;
      yinit_q <= yInit;
    end
  end
  // pixel stage aligned with the ROM's one-cycle read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_q    <= 1'b0;
      clip_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      pix_q    <= state_q == DRAW;
      clip_q   <= xs > 9'(SCREEN_W - 1) || ys > 8'(SCREEN_H - 1);
      colour_q <= colour;
      if (state_q == DRAW) begin
        x_q <= xs[7:0];
        y_q <= ys[6:0];
      end
    end
  end
  assign x      = x_q;
  assign y      = y_q;
  assign colour = pix_q ? (black_q ? 3'b000 : romData) : colour_q;
  assign plot   = pix_q && !clip_q;
endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: transaction-level model check of draw_engine with directed draws
module tb_draw_engine;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        spriteMode = 1'b0;
  logic [7:0]  xInit = '0;
  logic [6:0]  yInit = '0;
  logic        black = 1'b0;
  logic [2:0]  romData = '0;
  logic [14:0] romAddr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int vecs = 0, errs = 0;
  int mk = -1, mW = 0, mH = 0, mx = 0, my = 0;
  bit mb = 0;
  int plot_cnt = 0, done_cnt = 0, nz_cnt = 0, done_at = 0, first_k = 0;
  int first_x = 0, first_y = 0, first_c = 0, last_x = 0, last_y = 0;
  int mp, p, ex, ey;
  bit vis, slot_seen = 0;

  draw_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .spriteMode (spriteMode),
    .xInit      (xInit),
    .yInit      (yInit),
    .black      (black),
    .romData    (romData),
    .romAddr    (romAddr),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) romData <= romAddr[2:0];

  task automatic chk(input string n, input int a, input int e);
    vecs++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  // model: mk counts cycles since the accepting edge (-1 = idle)
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mk <= -1;
    else if (mk == -1) begin
      if (start) begin
        mk <= 1;
        mW <= spriteMode ? 40 : 160;
        mH <= spriteMode ? 40 : 120;
        mx <= int'(xInit);
        my <= int'(yInit);
        mb <= black;
      end
    end else if (mk >= mW * mH + 2) mk <= -1;
    else mk <= mk + 1;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_addr", romAddr, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      slot_seen = 0;
    end else begin
      mp = mW * mH;
      if (mk == 1) begin
        plot_cnt = 0;
        done_cnt = 0;
        nz_cnt = 0;
      end
      chk("addr", romAddr, (mk >= 1 && mk <= mp) ? mk - 1 : 0);
      chk("busy", busy, int'(mk >= 1 && mk <= mp + 1));
      chk("done", done, int'(mk == mp + 2));
      if (mk >= 2 && mk <= mp + 1) begin
        p = mk - 2;
        ex = mx + p % mW;
        ey = my + p / mW;
        vis = ex < 160 && ey < 120;
        chk("plot", plot, int'(vis));
        if (vis) begin
          chk("x", x, ex);
          chk("y", y, ey);
          chk("colour", colour, mb ? 0 : p % 8);
        end
        slot_seen = 1;
      end else begin
        chk("plot_idle", plot, 0);
        if (!slot_seen) begin
          chk("x_init", x, 0);
          chk("y_init", y, 0);
          chk("colour_init", colour, 0);
        end
      end
      if (plot) begin
        if (plot_cnt == 0) begin
          first_x = x;
          first_y = y;
          first_c = colour;
          first_k = mk;
        end
        last_x = x;
        last_y = y;
        if (colour != 0) nz_cnt++;
        plot_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_at = mk;
      end
    end
  end

  task automatic draw(input bit sm, input int xi, input int yi, input bit b);
    spriteMode = sm;
    xInit = 8'(xi);
    yInit = 7'(yi);
    black = b;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string n, input int lim);
    int c = 0;
    while (done_cnt == 0 && c < lim) begin
      @(negedge clk); #2;
      c++;
    end
    chk(n, int'(done_cnt > 0), 1);
  endtask

  task automatic settle_one_done(input string n);
    repeat (4) @(negedge clk);
    #2;
    chk(n, done_cnt, 1);
  endtask

  initial begin
    int c;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk); #2;

    draw(1'b1, 10, 20, 1'b0);
    wait_done("t1_wait", 3000);
    chk("t1_plots", plot_cnt, 1600);
    chk("t1_first_x", first_x, 10);
    chk("t1_first_y", first_y, 20);
    chk("t1_first_c", first_c, 0);
    chk("t1_first_k", first_k, 2);
    chk("t1_last_x", last_x, 49);
    chk("t1_last_y", last_y, 59);
    chk("t1_done_at", done_at, 1602);
    settle_one_done("t1_done_pulses");

    draw(1'b0, 0, 0, 1'b1);
    wait_done("t2_wait", 25000);
    chk("t2_plots", plot_cnt, 19200);
    chk("t2_nonzero_colour", nz_cnt, 0);
    chk("t2_last_x", last_x, 159);
    chk("t2_last_y", last_y, 119);
    chk("t2_done_at", done_at, 19202);
    settle_one_done("t2_done_pulses");

    draw(1'b1, 140, 100, 1'b0);
    wait_done("t3_wait", 3000);
    chk("t3_plots", plot_cnt, 400);
    chk("t3_first_x", first_x, 140);
    chk("t3_first_y", first_y, 100);
    chk("t3_last_x", last_x, 159);
    chk("t3_last_y", last_y, 119);
    chk("t3_done_at", done_at, 1602);
    settle_one_done("t3_done_pulses");

    spriteMode = 1'b1;
    xInit = 8'd0;
    yInit = 7'd0;
    black = 1'b0;
    start = 1'b1;
    @(negedge clk); #2;
    wait_done("t4a_wait", 3000);
    chk("t4a_plots", plot_cnt, 1600);
    chk("t4a_done_pulses", done_cnt, 1);
    c = 0;
    while (mk != 1 && c < 10) begin
      @(negedge clk); #2;
      c++;
    end
    chk("t4_reaccept_gap", c, 2);
    start = 1'b0;
    wait_done("t4b_wait", 3000);
    chk("t4b_plots", plot_cnt, 1600);
    chk("t4b_first_k", first_k, 2);
    settle_one_done("t4b_done_pulses");
    chk("t4_idle_busy", busy, 0);

    draw(1'b1, 0, 0, 1'b0);
    c = 0;
    while (plot_cnt < 500 && c < 3000) begin
      @(negedge clk); #2;
      c++;
    end
    chk("t5_partial", plot_cnt, 500);
    resetn = 1'b0;
    #1;
    chk("t5_async_addr", romAddr, 0);
    chk("t5_async_x", x, 0);
    chk("t5_async_y", y, 0);
    chk("t5_async_colour", colour, 0);
    chk("t5_async_plot", plot, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_done", done, 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("t5_no_done", done_cnt, 0);
    draw(1'b1, 0, 0, 1'b0);
    wait_done("t5_wait", 3000);
    chk("t5_plots", plot_cnt, 1600);
    chk("t5_done_at", done_at, 1602);
    settle_one_done("t5_done_pulses");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
